// File: rtl/grid_readback_if.sv
// Memory-side bus of grid_readback: grid RAM read port, edge ROMs and the
// shared-address position RAM pair.
interface grid_readback_if;
    logic               grid_re;
    logic        [31:0] grid_addr;
    logic signed [31:0] grid_dout;

    logic               ea_re;
    logic               eb_re;
    logic        [31:0] ea_addr;
    logic        [31:0] eb_addr;
    logic signed [31:0] ea_dout;
    logic signed [31:0] eb_dout;

    logic               pos_re;
    logic               pos_we;
    logic        [31:0] pos_addr;
    logic signed [31:0] pos_din_x;
    logic signed [31:0] pos_din_y;
    logic signed [31:0] pos_dout_x;
    logic signed [31:0] pos_dout_y;

    modport master (
        output grid_re, grid_addr, ea_re, eb_re, ea_addr, eb_addr,
               pos_re, pos_we, pos_addr, pos_din_x, pos_din_y,
        input  grid_dout, ea_dout, eb_dout, pos_dout_x, pos_dout_y
    );

    modport slave (
        input  grid_re, grid_addr, ea_re, eb_re, ea_addr, eb_addr,
               pos_re, pos_we, pos_addr, pos_din_x, pos_din_y,
        output grid_dout, ea_dout, eb_dout, pos_dout_x, pos_dout_y
    );
endinterface

// File: rtl/grid_readback.sv
// Readback/check stage after placement: rebuilds node positions from the grid
// RAM, flags range/duplicate errors, then replays the edge list to compute an
// independent wirelength-style cost.
//
// state | meaning
// IDLE  | waiting for start
// CLR   | writing -1 to every position entry, clearing the seen bitmap
// SCAN  | issue grid read for cell c, or move to edge replay when c==N*N
// WG    | grid read latency
// CHK   | validate grid word, record position
// EDGE  | issue edge ROM reads for edge e, or finish when e==N_EDGE
// WE    | edge ROM latency
// PA    | latch endpoint b, issue position read for endpoint a
// WA    | position read latency (a)
// PB    | latch xa/ya, issue position read for endpoint b
// WB    | position read latency (b)
// ACC   | check both endpoints placed, accumulate cost
// DONE  | finished cleanly
// ERR   | finished with err_code
module grid_readback #(
    parameter int N      = 6,
    parameter int NODES  = 32,
    parameter int N_EDGE = 29
) (
    input  logic            clk_i,
    input  logic            reset_ni,
    input  logic            start_i,
    output logic            busy_o,
    output logic            done_o,
    output logic            error_o,
    output logic [1:0]      err_code_o,
    output logic [31:0]     cost_o,
    output logic [31:0]     placed_o,
    grid_readback_if.master mem
);

    localparam int CELLS = N * N;
    localparam int NW    = (NODES > 1) ? $clog2(NODES) : 1;
    localparam logic signed [31:0] NODES_S = NODES;
    localparam logic signed [31:0] EMPTY   = -32'sd1;

    typedef enum logic [3:0] {
        S_IDLE, S_CLR, S_SCAN, S_WG, S_CHK, S_EDGE, S_WE,
        S_PA, S_WA, S_PB, S_WB, S_ACC, S_DONE, S_ERR
    } state_t;

    state_t             state_q, state_d;
    logic        [31:0] clr_q, clr_d;
    logic        [31:0] c_q, c_d;
    logic        [31:0] row_q, row_d;
    logic        [31:0] col_q, col_d;
    logic        [31:0] e_q, e_d;
    logic signed [31:0] b_q, b_d;
    logic signed [31:0] xa_q, xa_d;
    logic signed [31:0] ya_q, ya_d;
    logic        [31:0] cost_q, cost_d;
    logic        [31:0] placed_q, placed_d;
    logic        [1:0]  err_code_q, err_code_d;
    logic [NODES-1:0]   seen_q, seen_d;
    logic               grid_re_q, grid_re_d;
    logic        [31:0] grid_addr_q, grid_addr_d;
    logic               edge_re_q, edge_re_d;
    logic        [31:0] edge_addr_q, edge_addr_d;
    logic               pos_re_q, pos_re_d;
    logic               pos_we_q, pos_we_d;
    logic        [31:0] pos_addr_q, pos_addr_d;
    logic signed [31:0] pos_din_x_q, pos_din_x_d;
    logic signed [31:0] pos_din_y_q, pos_din_y_d;

    logic signed [31:0] grid_d;
    logic               cell_empty, id_bad, id_dup, unplaced;
    logic [NW-1:0]      id_idx;
    logic signed [31:0] dx, dy, adx, ady;

    // Decode of the grid word and the endpoint distance terms used by CHK/ACC.
    always_comb begin
        grid_d     = mem.grid_dout;
        id_idx     = grid_d[NW-1:0];
        cell_empty = (grid_d == EMPTY);
        id_bad     = (grid_d < EMPTY) || (grid_d >= NODES_S);
        id_dup     = seen_q[id_idx];
        unplaced   = (xa_q == EMPTY) || (mem.pos_dout_x == EMPTY);
        dx         = xa_q - mem.pos_dout_x;
        dy         = ya_q - mem.pos_dout_y;
        adx        = dx[31] ? -dx : dx;
        ady        = dy[31] ? -dy : dy;
    end

    // State register.
    always_ff @(posedge clk_i) begin
        if (!reset_ni) state_q <= S_IDLE;
        else           state_q <= state_d;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE, S_DONE, S_ERR: if (start_i) state_d = S_CLR;
            S_CLR:  if (clr_q == 32'(NODES - 1)) state_d = S_SCAN;
            S_SCAN: state_d = (c_q == 32'(CELLS)) ? S_EDGE : S_WG;
            S_WG:   state_d = S_CHK;
            S_CHK: begin
                if (cell_empty)  state_d = S_SCAN;
                else if (id_bad) state_d = S_ERR;
                else if (id_dup) state_d = S_ERR;
                else             state_d = S_SCAN;
            end
            S_EDGE: state_d = (e_q == 32'(N_EDGE)) ? S_DONE : S_WE;
            S_WE:   state_d = S_PA;
            S_PA:   state_d = S_WA;
            S_WA:   state_d = S_PB;
            S_PB:   state_d = S_WB;
            S_WB:   state_d = S_ACC;
            S_ACC:  state_d = unplaced ? S_ERR : S_EDGE;
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath next values, memory strobes and status outputs.
    always_comb begin
        clr_d       = clr_q;
        c_d         = c_q;
        row_d       = row_q;
        col_d       = col_q;
        e_d         = e_q;
        b_d         = b_q;
        xa_d        = xa_q;
        ya_d        = ya_q;
        cost_d      = cost_q;
        placed_d    = placed_q;
        err_code_d  = err_code_q;
        seen_d      = seen_q;
        grid_re_d   = 1'b0;
        grid_addr_d = grid_addr_q;
        edge_re_d   = 1'b0;
        edge_addr_d = edge_addr_q;
        pos_re_d    = 1'b0;
        pos_we_d    = 1'b0;
        pos_addr_d  = pos_addr_q;
        pos_din_x_d = pos_din_x_q;
        pos_din_y_d = pos_din_y_q;

        busy_o  = !(state_q inside {S_IDLE, S_DONE, S_ERR});
        done_o  = (state_q == S_DONE) || (state_q == S_ERR);
        error_o = (state_q == S_ERR);

        unique case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (start_i) begin
                    cost_d     = '0;
                    placed_d   = '0;
                    err_code_d = 2'd0;
                    clr_d      = '0;
                end
            end
            S_CLR: begin
                pos_we_d    = 1'b1;
                pos_addr_d  = clr_q;
                pos_din_x_d = EMPTY;
                pos_din_y_d = EMPTY;
                clr_d       = clr_q + 32'd1;
                seen_d      = '0;
                c_d         = '0;
                row_d       = '0;
                col_d       = '0;
            end
            S_SCAN: begin
                if (c_q == 32'(CELLS)) begin
                    e_d = '0;
                end else begin
                    grid_re_d   = 1'b1;
                    grid_addr_d = c_q;
                end
            end
            S_CHK: begin
                if (!cell_empty && id_bad) begin
                    err_code_d = 2'd1;
                end else if (!cell_empty && id_dup) begin
                    err_code_d = 2'd2;
                end else begin
                    if (!cell_empty) begin
                        seen_d[id_idx] = 1'b1;
                        placed_d       = placed_q + 32'd1;
                        pos_we_d       = 1'b1;
                        pos_addr_d     = grid_d;
                        pos_din_x_d    = row_q;
                        pos_din_y_d    = col_q;
                    end
                    // Row/column track c so c/N and c%N need no divider.
                    c_d = c_q + 32'd1;
                    if (col_q == 32'(N - 1)) begin
                        col_d = '0;
                        row_d = row_q + 32'd1;
                    end else begin
                        col_d = col_q + 32'd1;
                    end
                end
            end
            S_EDGE: begin
                if (e_q != 32'(N_EDGE)) begin
                    edge_re_d   = 1'b1;
                    edge_addr_d = e_q;
                end
            end
            S_PA: begin
                b_d        = mem.eb_dout;
                pos_re_d   = 1'b1;
                pos_addr_d = mem.ea_dout;
            end
            S_PB: begin
                xa_d       = mem.pos_dout_x;
                ya_d       = mem.pos_dout_y;
                pos_re_d   = 1'b1;
                pos_addr_d = b_q;
            end
            S_ACC: begin
                if (unplaced) begin
                    err_code_d = 2'd3;
                end else begin
                    cost_d = cost_q + adx + ady - 32'd1;
                    e_d    = e_q + 32'd1;
                end
            end
            default: ;
        endcase
    end

    // Datapath and strobe registers.
    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            clr_q       <= '0;
            c_q         <= '0;
            row_q       <= '0;
            col_q       <= '0;
            e_q         <= '0;
            b_q         <= '0;
            xa_q        <= '0;
            ya_q        <= '0;
            cost_q      <= '0;
            placed_q    <= '0;
            err_code_q  <= 2'd0;
            seen_q      <= '0;
            grid_re_q   <= 1'b0;
            grid_addr_q <= '0;
            edge_re_q   <= 1'b0;
            edge_addr_q <= '0;
            pos_re_q    <= 1'b0;
            pos_we_q    <= 1'b0;
            pos_addr_q  <= '0;
            pos_din_x_q <= '0;
            pos_din_y_q <= '0;
        end else begin
            clr_q       <= clr_d;
            c_q         <= c_d;
            row_q       <= row_d;
            col_q       <= col_d;
            e_q         <= e_d;
            b_q         <= b_d;
            xa_q        <= xa_d;
            ya_q        <= ya_d;
            cost_q      <= cost_d;
            placed_q    <= placed_d;
            err_code_q  <= err_code_d;
            seen_q      <= seen_d;
            grid_re_q   <= grid_re_d;
            grid_addr_q <= grid_addr_d;
            edge_re_q   <= edge_re_d;
            edge_addr_q <= edge_addr_d;
            pos_re_q    <= pos_re_d;
            pos_we_q    <= pos_we_d;
            pos_addr_q  <= pos_addr_d;
            pos_din_x_q <= pos_din_x_d;
            pos_din_y_q <= pos_din_y_d;
        end
    end

    assign err_code_o    = err_code_q;
    assign cost_o        = cost_q;
    assign placed_o      = placed_q;
    assign mem.grid_re   = grid_re_q;
    assign mem.grid_addr = grid_addr_q;
    assign mem.ea_re     = edge_re_q;
    assign mem.eb_re     = edge_re_q;
    assign mem.ea_addr   = edge_addr_q;
    assign mem.eb_addr   = edge_addr_q;
    assign mem.pos_re    = pos_re_q;
    assign mem.pos_we    = pos_we_q;
    assign mem.pos_addr  = pos_addr_q;
    assign mem.pos_din_x = pos_din_x_q;
    assign mem.pos_din_y = pos_din_y_q;

endmodule

// File: tb/tb_grid_readback.sv
// Bench for grid_readback: behavioural memories, a direct reference model of
// the scan/replay rules, and one task per scenario.
module tb_grid_readback;
    localparam int N      = 6;
    localparam int NODES  = 32;
    localparam int N_EDGE = 29;
    localparam int CELLS  = N * N;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic        load_junk = 1'b0;
    logic        busy, done, error;
    logic [1:0]  err_code;
    logic [31:0] cost, placed;

    grid_readback_if bus();

    grid_readback #(.N(N), .NODES(NODES), .N_EDGE(N_EDGE)) dut (
        .clk_i      (clk),
        .reset_ni   (reset_n),
        .start_i    (start),
        .busy_o     (busy),
        .done_o     (done),
        .error_o    (error),
        .err_code_o (err_code),
        .cost_o     (cost),
        .placed_o   (placed),
        .mem        (bus)
    );

    always #5 clk = ~clk;

    int grid_mem [CELLS];
    int ea_mem   [N_EDGE];
    int eb_mem   [N_EDGE];
    int posx_mem [NODES];
    int posy_mem [NODES];

    int n_checks = 0;
    int n_fail   = 0;

    // Memories: read data appears one edge after the strobe.
    always @(posedge clk) begin
        if (bus.grid_re)
            bus.grid_dout <= (bus.grid_addr < CELLS) ? grid_mem[bus.grid_addr] : 32'h0BAD_0BAD;
        if (bus.ea_re) bus.ea_dout <= (bus.ea_addr < N_EDGE) ? ea_mem[bus.ea_addr] : 0;
        if (bus.eb_re) bus.eb_dout <= (bus.eb_addr < N_EDGE) ? eb_mem[bus.eb_addr] : 0;
        if (load_junk) begin
            for (int i = 0; i < NODES; i++) begin
                posx_mem[i] <= int'($urandom_range(500, 0));
                posy_mem[i] <= int'($urandom_range(500, 0));
            end
        end else if (bus.pos_we && bus.pos_addr < NODES) begin
            posx_mem[bus.pos_addr] <= bus.pos_din_x;
            posy_mem[bus.pos_addr] <= bus.pos_din_y;
        end
        if (bus.pos_re && bus.pos_addr < NODES) begin
            bus.pos_dout_x <= posx_mem[bus.pos_addr];
            bus.pos_dout_y <= posy_mem[bus.pos_addr];
        end
    end

    // Position RAM port must never read and write in the same cycle.
    always @(negedge clk) begin
        if (reset_n && (bus.pos_re || bus.pos_we)) begin
            n_checks++;
            if (bus.pos_re && bus.pos_we) begin
                n_fail++;
                $display("FAIL pos_port_excl: got re=%0b we=%0b expected not both", bus.pos_re, bus.pos_we);
            end
        end
    end

    // Reference model results.
    int exp_placed, exp_cost, exp_code;
    bit exp_err;
    int exp_x [NODES];
    int exp_y [NODES];

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    function automatic void model();
        bit seen [NODES];
        bit stop = 1'b0;
        exp_placed = 0; exp_cost = 0; exp_code = 0; exp_err = 1'b0;
        for (int i = 0; i < NODES; i++) begin
            exp_x[i] = -1; exp_y[i] = -1; seen[i] = 1'b0;
        end
        for (int c = 0; c < CELLS && !stop; c++) begin
            int d;
            d = grid_mem[c];
            if (d != -1) begin
                if (d < -1 || d >= NODES) begin
                    exp_err = 1'b1; exp_code = 1; stop = 1'b1;
                end else if (seen[d]) begin
                    exp_err = 1'b1; exp_code = 2; stop = 1'b1;
                end else begin
                    seen[d] = 1'b1;
                    exp_placed++;
                    exp_x[d] = c / N;
                    exp_y[d] = c % N;
                end
            end
        end
        for (int e = 0; e < N_EDGE && !stop; e++) begin
            int a, b;
            a = ea_mem[e];
            b = eb_mem[e];
            if (exp_x[a] == -1 || exp_x[b] == -1) begin
                exp_err = 1'b1; exp_code = 3; stop = 1'b1;
            end else begin
                exp_cost += iabs(exp_x[a] - exp_x[b]) + iabs(exp_y[a] - exp_y[b]) - 1;
            end
        end
    endfunction

    task automatic clear_grid();
        for (int i = 0; i < CELLS; i++) grid_mem[i] = -1;
    endtask

    task automatic t1_setup();
        clear_grid();
        grid_mem[0] = 0;
        grid_mem[7] = 1;
        for (int e = 0; e < N_EDGE; e++) begin
            ea_mem[e] = (e % 2 == 0) ? 0 : 1;
            eb_mem[e] = (e % 2 == 0) ? 1 : 0;
        end
        ea_mem[5] = 1;  eb_mem[5] = 1;
        ea_mem[28] = 0; eb_mem[28] = 0;
    endtask

    // Pulse start (optionally re-pulse it mid-run) and wait for done.
    task automatic run_op(input bit mid_start);
        bit finished = 1'b0;
        @(negedge clk); start = 1'b1; load_junk = 1'b1;
        @(negedge clk); start = 1'b0; load_junk = 1'b0;
        n_checks++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL busy_after_start: got busy=%0b done=%0b expected busy=1 done=0", busy, done);
        end
        for (int cyc = 0; cyc < 3000 && !finished; cyc++) begin
            @(negedge clk);
            if (done) finished = 1'b1;
            start = (mid_start && !finished && cyc == 100) ? 1'b1 : 1'b0;
        end
        start = 1'b0;
        n_checks++;
        if (!finished) begin
            n_fail++;
            $display("FAIL run_timeout: got done=%0b expected done=1 within 3000 cycles", done);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({busy, done, error} !== 3'b000 || err_code !== 2'd0) begin
            n_fail++;
            $display("FAIL reset_status: got busy=%0b done=%0b error=%0b code=%0d expected all 0", busy, done, error, err_code);
        end
        n_checks++;
        if (cost !== 32'd0 || placed !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_counts: got cost=%0d placed=%0d expected 0 0", cost, placed);
        end
        n_checks++;
        if ({bus.grid_re, bus.ea_re, bus.eb_re, bus.pos_re, bus.pos_we} !== 5'b0 ||
            bus.grid_addr !== 32'd0 || bus.pos_addr !== 32'd0 || bus.ea_addr !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_bus: got strobes=%b grid_addr=%0d pos_addr=%0d expected 0", {bus.grid_re, bus.ea_re, bus.eb_re, bus.pos_re, bus.pos_we}, bus.grid_addr, bus.pos_addr);
        end
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        t1_setup();
        model();
        run_op(1'b0);
        n_checks++;
        if (done !== 1'b1 || error !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_status: got done=%0b error=%0b busy=%0b expected 1 0 0", done, error, busy);
        end
        n_checks++;
        if (placed !== 32'd2) begin
            n_fail++;
            $display("FAIL basic_placed: got %0d expected 2", placed);
        end
        n_checks++;
        if (cost !== 32'(exp_cost)) begin
            n_fail++;
            $display("FAIL basic_cost: got %0d expected %0d", $signed(cost), exp_cost);
        end
        n_checks++;
        if (posx_mem[0] !== 0 || posy_mem[0] !== 0 || posx_mem[1] !== 1 || posy_mem[1] !== 1) begin
            n_fail++;
            $display("FAIL basic_pos: got p0=(%0d,%0d) p1=(%0d,%0d) expected (0,0) (1,1)", posx_mem[0], posy_mem[0], posx_mem[1], posy_mem[1]);
        end
        for (int i = 2; i < NODES; i++) begin
            n_checks++;
            if (posx_mem[i] !== -1 || posy_mem[i] !== -1) begin
                n_fail++;
                $display("FAIL basic_pos_clr: node %0d got (%0d,%0d) expected (-1,-1)", i, posx_mem[i], posy_mem[i]);
            end
        end
    endtask

    task automatic test_duplicate();
        clear_grid();
        grid_mem[3]  = 5;
        grid_mem[20] = 5;
        model();
        run_op(1'b0);
        n_checks++;
        if (error !== 1'b1 || err_code !== 2'd2 || err_code !== 2'(exp_code)) begin
            n_fail++;
            $display("FAIL dup_code: got error=%0b code=%0d expected 1 2", error, err_code);
        end
        n_checks++;
        if (placed !== 32'd1 || placed !== 32'(exp_placed)) begin
            n_fail++;
            $display("FAIL dup_placed: got %0d expected 1", placed);
        end
    endtask

    task automatic test_range();
        int bad [4] = '{40, -7, 32, -2};
        for (int k = 0; k < 4; k++) begin
            clear_grid();
            grid_mem[2]  = 31;
            grid_mem[10] = bad[k];
            model();
            run_op(1'b0);
            n_checks++;
            if (error !== 1'b1 || err_code !== 2'd1) begin
                n_fail++;
                $display("FAIL range_code[%0d]: got error=%0b code=%0d expected 1 1", bad[k], error, err_code);
            end
            n_checks++;
            if (placed !== 32'(exp_placed) || cost !== 32'd0) begin
                n_fail++;
                $display("FAIL range_counts[%0d]: got placed=%0d cost=%0d expected %0d 0", bad[k], placed, cost, exp_placed);
            end
        end
    endtask

    task automatic test_unplaced();
        int perm [CELLS];
        for (int i = 0; i < CELLS; i++) perm[i] = i;
        for (int i = CELLS - 1; i > 0; i--) begin
            int j, t;
            j = int'($urandom_range(i, 0));
            t = perm[i]; perm[i] = perm[j]; perm[j] = t;
        end
        clear_grid();
        for (int i = 0; i < 9; i++) grid_mem[perm[i]] = i;
        for (int e = 0; e < N_EDGE; e++) begin
            ea_mem[e] = int'($urandom_range(8, 0));
            eb_mem[e] = int'($urandom_range(8, 0));
        end
        ea_mem[4] = 2; eb_mem[4] = 9;
        model();
        run_op(1'b0);
        n_checks++;
        if (error !== 1'b1 || err_code !== 2'd3) begin
            n_fail++;
            $display("FAIL unplaced_code: got error=%0b code=%0d expected 1 3", error, err_code);
        end
        n_checks++;
        if (cost !== 32'(exp_cost) || placed !== 32'd9) begin
            n_fail++;
            $display("FAIL unplaced_cost: got cost=%0d placed=%0d expected %0d 9", $signed(cost), placed, exp_cost);
        end
    endtask

    task automatic test_empty();
        clear_grid();
        model();
        run_op(1'b0);
        n_checks++;
        if (error !== 1'b1 || err_code !== 2'd3 || placed !== 32'd0 || cost !== 32'd0) begin
            n_fail++;
            $display("FAIL empty_grid: got error=%0b code=%0d placed=%0d cost=%0d expected 1 3 0 0", error, err_code, placed, cost);
        end
    endtask

    task automatic test_random_full();
        for (int it = 0; it < 4; it++) begin
            int perm [CELLS];
            for (int i = 0; i < CELLS; i++) perm[i] = i;
            for (int i = CELLS - 1; i > 0; i--) begin
                int j, t;
                j = int'($urandom_range(i, 0));
                t = perm[i]; perm[i] = perm[j]; perm[j] = t;
            end
            clear_grid();
            for (int i = 0; i < NODES; i++) grid_mem[perm[i]] = i;
            for (int e = 0; e < N_EDGE; e++) begin
                ea_mem[e] = int'($urandom_range(NODES - 1, 0));
                eb_mem[e] = ($urandom_range(7, 0) == 0) ? ea_mem[e] : int'($urandom_range(NODES - 1, 0));
            end
            model();
            run_op(1'b1);
            n_checks++;
            if (error !== 1'b0 || done !== 1'b1) begin
                n_fail++;
                $display("FAIL full_status[%0d]: got error=%0b code=%0d done=%0b expected 0 1", it, error, err_code, done);
            end
            n_checks++;
            if (cost !== 32'(exp_cost) || placed !== 32'(NODES)) begin
                n_fail++;
                $display("FAIL full_cost[%0d]: got cost=%0d placed=%0d expected %0d %0d", it, $signed(cost), placed, exp_cost, NODES);
            end
            for (int i = 0; i < NODES; i++) begin
                n_checks++;
                if (posx_mem[i] !== exp_x[i] || posy_mem[i] !== exp_y[i]) begin
                    n_fail++;
                    $display("FAIL full_pos[%0d] node %0d: got (%0d,%0d) expected (%0d,%0d)", it, i, posx_mem[i], posy_mem[i], exp_x[i], exp_y[i]);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        bit seen11 = 1'b0;
        t1_setup();
        model();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        for (int cyc = 0; cyc < 500 && !seen11; cyc++) begin
            @(negedge clk);
            if (bus.grid_re && bus.grid_addr == 32'd11) seen11 = 1'b1;
        end
        n_checks++;
        if (!seen11) begin
            n_fail++;
            $display("FAIL midreset_reach: got no read of cell 11 expected one within 500 cycles");
        end
        repeat (2) @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0 || cost !== 32'd0 || placed !== 32'd0 || bus.grid_re !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_state: got busy=%0b done=%0b cost=%0d placed=%0d grid_re=%0b expected all 0", busy, done, cost, placed, bus.grid_re);
        end
        reset_n = 1'b1;
        run_op(1'b0);
        n_checks++;
        if (error !== 1'b0 || placed !== 32'd2 || cost !== 32'(exp_cost)) begin
            n_fail++;
            $display("FAIL midreset_rerun: got error=%0b placed=%0d cost=%0d expected 0 2 %0d", error, placed, $signed(cost), exp_cost);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_duplicate();
        test_range();
        test_unplaced();
        test_empty();
        test_random_full();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
